// File: rtl/fft8_pkg.sv
// fft8_pkg: definitions shared by the 8-point radix-2 DIT FFT stages.
//   FFT_N / LOG2N / DATA_W : frame length, index width and default sample width
//   idx_t                  : sample index within a frame
//   bitrev3()              : 3-bit bit reversal
//   PAIR_A_IDX             : upper-operand sample index for each butterfly pair;
//                            the lower operand is always that index + FFT_N/2
package fft8_pkg;

  localparam int FFT_N  = 8;
  localparam int LOG2N  = 3;
  localparam int DATA_W = 16;
  localparam int NPAIRS = FFT_N / 2;

  typedef logic [LOG2N-1:0] idx_t;

  function automatic idx_t bitrev3(input idx_t i);
    return {i[0], i[1], i[2]};
  endfunction

  // Pair p takes x[bitrev3(2p)] and x[bitrev3(2p)+4]: (0,4) (2,6) (1,5) (3,7).
  localparam idx_t PAIR_A_IDX [NPAIRS] = '{
    bitrev3(idx_t'(0)), bitrev3(idx_t'(2)), bitrev3(idx_t'(4)), bitrev3(idx_t'(6))
  };

endpackage

// File: rtl/fft8_bank.sv
// fft8_bank: one 8-entry register bank, single write port, two combinational
// read ports.
//   clk, rst             : clock, asynchronous active-low reset (clears contents)
//   we, waddr, wdata     : synchronous write port
//   raddr_a / rdata_a    : combinational read port A
//   raddr_b / rdata_b    : combinational read port B
module fft8_bank
  import fft8_pkg::*;
#(
  parameter int DATA_W = fft8_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  idx_t              waddr,
  input  logic [DATA_W-1:0] wdata,
  input  idx_t              raddr_a,
  input  idx_t              raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [FFT_N];

  // NOTE: storage is reset on purpose: a reset must discard any buffered frame
  // and force the combinational read data (the stage outputs) to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FFT_N; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/fft8_input_reorder.sv
// fft8_input_reorder: input stage of the 8-point DIT FFT. Collects natural-order
// samples into a ping-pong bank pair and drains each frame as four bit-reversed
// butterfly operand pairs (x0,x4) (x2,x6) (x1,x5) (x3,x7).
//   clk, rst                     : clock, asynchronous active-low reset
//   in_valid, in_sof, in_data    : sample input (in_sof restarts the frame)
//   in_ready                     : write bank is free
//   out_valid, out_ready         : pair handshake
//   out_a, out_b                 : butterfly operands, out_b index = out_a index + 4
//   out_pair, out_sof            : pair number in frame, first-pair marker
module fft8_input_reorder
  import fft8_pkg::*;
#(
  parameter int DATA_W = fft8_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [1:0]        out_pair,
  output logic              out_sof
);

  logic       wr_bank, rd_bank;
  idx_t       wr_idx;
  logic [1:0] rd_pair;
  logic [1:0] full, full_nxt;

  logic       accept, handshake;
  idx_t       waddr;
  logic       wr_last, rd_last;
  idx_t       raddr_a, raddr_b;

  logic [DATA_W-1:0] rdata_a [2];
  logic [DATA_W-1:0] rdata_b [2];

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;

  // A start-of-frame sample always lands at index 0, dropping any partial frame.
  assign waddr   = in_sof ? '0 : wr_idx;
  assign wr_last = (waddr == idx_t'(FFT_N - 1));
  assign rd_last = (rd_pair == 2'(NPAIRS - 1));

  // Write and read only ever touch different banks (one is full, one is not),
  // so each bank's full flag has a single updater per cycle.
  // NOTE: combinational blocks use blocking assignments with a default first,
  // so every path assigns full_nxt and no latch is inferred.
  always_comb begin
    full_nxt = full;
    if (handshake && rd_last) full_nxt[rd_bank] = 1'b0;
    if (accept && wr_last)    full_nxt[wr_bank] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank <= 1'b0;
      wr_idx  <= '0;
      rd_bank <= 1'b0;
      rd_pair <= '0;
      full    <= '0;
    end else begin
      full <= full_nxt;
      if (accept) begin
        if (wr_last) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx  <= waddr + idx_t'(1);
        end
      end
      if (handshake) begin
        rd_pair <= rd_pair + 2'd1;
        if (rd_last) rd_bank <= ~rd_bank;
      end
    end
  end

  assign raddr_a = PAIR_A_IDX[rd_pair];
  assign raddr_b = raddr_a + idx_t'(NPAIRS);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft8_bank #(.DATA_W(DATA_W)) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we      (accept && (wr_bank == 1'(b))),
      .waddr   (waddr),
      .wdata   (in_data),
      .raddr_a (raddr_a),
      .raddr_b (raddr_b),
      .rdata_a (rdata_a[b]),
      .rdata_b (rdata_b[b])
    );
  end

  assign out_a    = rdata_a[rd_bank];
  assign out_b    = rdata_b[rd_bank];
  assign out_pair = rd_pair;
  assign out_sof  = out_valid && (rd_pair == 2'd0);

endmodule

// File: tb/tb_fft8_input_reorder.sv
module tb_fft8_input_reorder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_a, out_b;
  logic [1:0]  out_pair;
  logic        out_sof;

  fft8_input_reorder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_pair  (out_pair),
    .out_sof   (out_sof)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;
  int stalls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Completed frames wait in a FIFO of capacity two; the head frame is emitted
  // pair by pair. Upper operand of pair p is sample a_idx[p], lower is +4.
  typedef logic [15:0] frame_t [8];
  frame_t fq[$];
  frame_t part;
  int     part_len = 0;
  int     rd_p = 0;
  int     a_idx [4];
  initial a_idx = '{0, 2, 1, 3};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fq.delete();
      part_len = 0;
      rd_p     = 0;
    end else begin
      automatic bit m_ready = (fq.size() < 2);
      automatic bit m_valid = (fq.size() > 0);
      if (m_valid && out_ready) begin
        rd_p++;
        if (rd_p == 4) begin
          rd_p = 0;
          fq.delete(0);
        end
      end
      if (in_valid && m_ready) begin
        if (in_sof) part_len = 0;
        part[part_len] = in_data;
        part_len++;
        if (part_len == 8) begin
          fq.push_back(part);
          part_len = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready", 32'(in_ready), 32'(fq.size() < 2));
      check("out_valid", 32'(out_valid), 32'(fq.size() > 0));
      if (fq.size() > 0) begin
        check("out_a", 32'(out_a), 32'(fq[0][a_idx[rd_p]]));
        check("out_b", 32'(out_b), 32'(fq[0][a_idx[rd_p] + 4]));
        check("out_pair", 32'(out_pair), 32'(rd_p));
        check("out_sof", 32'(out_sof), 32'(rd_p == 0));
      end else begin
        check("out_sof_idle", 32'(out_sof), 32'd0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a negedge; returns at the negedge after the sample is accepted.
  task automatic send(input logic [15:0] d, input bit sof);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    for (int t = 0; t < 100 && !done; t++) begin
      if (in_ready) done = 1'b1;
      else stalls++;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 50 && fq.size() > 0; t++) @(negedge clk);
    check("drain_empty", 32'(fq.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_a"}, 32'(out_a), 32'd0);
    check({tag, "_out_b"}, 32'(out_b), 32'd0);
    check({tag, "_out_pair"}, 32'(out_pair), 32'd0);
    check({tag, "_out_sof"}, 32'(out_sof), 32'd0);
  endtask

  logic [15:0] exp_a [4];
  logic [15:0] exp_b [4];
  logic [15:0] bvals [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- reset state ----
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #2 rst = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // ---- post-reset fill ----
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) send(16'h0100 + 16'(k), k == 0);
    exp_a = '{16'h0100, 16'h0102, 16'h0101, 16'h0103};
    exp_b = '{16'h0104, 16'h0106, 16'h0105, 16'h0107};
    for (int p = 0; p < 4; p++) begin
      check("fill_valid", 32'(out_valid), 32'd1);
      check("fill_a", 32'(out_a), 32'(exp_a[p]));
      check("fill_b", 32'(out_b), 32'(exp_b[p]));
      check("fill_pair", 32'(out_pair), 32'(p));
      check("fill_sof", 32'(out_sof), 32'(p == 0));
      @(negedge clk);
    end
    check("fill_done", 32'(out_valid), 32'd0);

    // ---- continuous streaming ----
    stalls = 0;
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < 8; k++) send(16'($urandom()), k == 0);
    check("stream_stalls", 32'(stalls), 32'd0);
    drain();

    // ---- back-pressure ----
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) send(16'h0200 + 16'(k), (k % 8) == 0);
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    for (int c = 0; c < 3; c++) begin
      check("bp_ready_low", 32'(in_ready), 32'd0);
      check("bp_hold_a", 32'(out_a), 32'h0200);
      check("bp_hold_b", 32'(out_b), 32'h0204);
      check("bp_hold_sof", 32'(out_sof), 32'd1);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("bp_release_ready", 32'(in_ready), 32'(k == 4));
    end
    check("bp_frame1_a", 32'(out_a), 32'h0208);
    drain();

    // ---- resync on in_sof ----
    for (int k = 0; k < 5; k++) send(16'h0300 + 16'(k), k == 0);
    send(16'h0182, 1'b1);
    for (int k = 0; k < 7; k++) send(16'h0183 + 16'(k), 1'b0);
    check("resync_valid", 32'(out_valid), 32'd1);
    check("resync_a", 32'(out_a), 32'h0182);
    check("resync_b", 32'(out_b), 32'h0186);
    drain();

    // ---- reset mid-frame ----
    for (int k = 0; k < 3; k++) send(16'h0400 + 16'(k), k == 0);
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_frame");
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // ---- reset mid-drain ----
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(16'h0410 + 16'(k), k == 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("middrain_pair", 32'(out_pair), 32'd1);
    out_ready = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_drain");
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) send(16'h0500 + 16'(k), k == 0);
    check("post_rst_a", 32'(out_a), 32'h0500);
    check("post_rst_b", 32'(out_b), 32'h0504);
    drain();

    // ---- boundary values ----
    bvals = '{16'h7F80, 16'h807F, 16'hFFFF, 16'h0000,
              16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int k = 0; k < 8; k++) send(bvals[k], k == 0);
    exp_a = '{16'h7F80, 16'hFFFF, 16'h807F, 16'h0000};
    exp_b = '{16'h1111, 16'h3333, 16'h2222, 16'h4444};
    for (int p = 0; p < 4; p++) begin
      check("bound_a", 32'(out_a), 32'(exp_a[p]));
      check("bound_b", 32'(out_b), 32'(exp_b[p]));
      @(negedge clk);
    end
    drain();

    // ---- randomized traffic ----
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sof    = ($urandom_range(0, 15) == 0);
      in_data   = 16'($urandom());
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft8_input_reorder.md
# fft8_input_reorder

Input stage of the 8-point radix-2 DIT FFT, sitting directly upstream of the first-stage `BF2` butterflies. It accepts one complex sample per cycle in natural order and buffers each 8-sample frame in a ping-pong pair of banks. It then emits the frame as four butterfly operand pairs in bit-reversed order, (x0,x4), (x2,x6), (x1,x5), (x3,x7), ready for `BF2` inputs `a`/`b`. One bank fills while the other drains, so a continuous input stream never stalls unless the consumer withholds `out_ready`.

## Interface
- `DATA_W`, 16: complex sample width; upper half real, lower half imaginary, both two's complement.
- `clk`, in, 1: clock; all state updates on its rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: `in_data` valid this cycle.
- `in_sof`, in, 1: start of frame; qualified by `in_valid`.
- `in_data`, in, DATA_W: input sample, natural order.
- `in_ready`, out, 1: stage can accept a sample this cycle.
- `out_valid`, out, 1: `out_a`/`out_b` hold a valid pair.
- `out_ready`, in, 1: consumer takes the pair this cycle.
- `out_a`, out, DATA_W: butterfly upper operand.
- `out_b`, out, DATA_W: butterfly lower operand, index +4 of `out_a`.
- `out_pair`, out, 2: pair index 0..3 within the frame.
- `out_sof`, out, 1: high with pair 0 of each frame.

## Operation
- **Storage:** two banks, each holding 8×DATA_W.
- **Write side state:** `wr_bank` (1 bit), `wr_idx` (3 bits), `full[1:0]`.
- **Read side state:** `rd_bank` (1 bit), `rd_pair` (2 bits).
- **Accepting a sample:** a sample is accepted when `in_valid && in_ready`. It is written to `bank[wr_bank][wr_idx]` and `wr_idx` increments.
- **Start of frame:** an accepted sample with `in_sof=1` is written at index 0 and `wr_idx` becomes 1. Any partial frame already in the write bank is discarded. `in_sof` with `wr_idx=0` is a no-op resync.
- **End of frame:** accepting the sample at `wr_idx=7` sets `full[wr_bank]`, toggles `wr_bank` and clears `wr_idx`.
- **Input ready:** `in_ready = !full[wr_bank]`, decoded from registered state only.
- **Output valid:** `out_valid = full[rd_bank]`.
- **Pair selection:** `rd_pair` maps to index pairs as 0→(0,4), 1→(2,6), 2→(1,5), 3→(3,7). The `out_a` index is bitrev3 of 2·`rd_pair`; the `out_b` index is the `out_a` index + 4.
- **Draining:** `rd_pair` increments on each `out_valid && out_ready`. A handshake at `rd_pair=3` clears `full[rd_bank]`, toggles `rd_bank` and wraps `rd_pair` to 0.
- **Output decode:** `out_sof = out_valid && rd_pair==0`. `out_a`/`out_b` are read combinationally from bank storage.
- **Data integrity:** samples pass through bit-exact, with no arithmetic and no width change.
- **Simultaneous fill and drain:** if the final write to one bank and the final read from the other happen in the same cycle, both take effect. `full` is updated per bank independently.
- **Bank freed and refilled:** when a bank is freed in cycle N, `in_ready` for that bank rises in cycle N+1, not in cycle N.
- **Both banks full:** `in_ready=0`, and `in_data` is ignored regardless of `in_valid`.
- **Reset mid-frame:** all state and storage clear asynchronously. The partial frame is lost.
- **Reset values:** `in_ready=1`, `out_valid=0`, `out_a=0`, `out_b=0`, `out_pair=0`, `out_sof=0`.

## Timing
- **Latency:** the last sample is accepted at edge N, and pair 0 is valid after that edge (cycle N+1).
- **Continuous streaming:** with `out_ready` held high, a frame drains in 4 cycles and fills in 8, so the input is never back-pressured.
- **Output hold:** pairs appear on consecutive cycles while `out_ready=1`. The outputs hold stable while `out_valid && !out_ready`.
- **Throughput:** one sample per cycle sustained in, one pair per cycle burst out.

## Structure
- **Shared package `fft8_pkg`:** holds `FFT_N=8`, `LOG2N=3`, `DATA_W=16` defaults, the `bitrev3` function and the pair-index constant table. Later stages (twiddle, reorder-out) use the same package.
- **Sub-module `fft8_bank`:** one 8-entry register bank with a single write port (`we`, `waddr`, `wdata`) and two combinational read ports. It is instantiated twice; ping-pong control stays in the top.

## Test plan
- **Post-reset fill:** after reset, stream 8 samples `16'h0100`..`16'h0107` with `out_ready=1`. Required: pairs (0100,0104), (0102,0106), (0101,0105), (0103,0107); `out_pair` 0..3; `out_sof` on the first pair only; first `out_valid` one cycle after the 8th sample.
- **Continuous streaming:** send 3 back-to-back frames with `out_ready=1`. Required: `in_ready` stays 1 throughout; 12 pairs appear in frame order.
- **Back-pressure:** hold `out_ready=0` while sending 16 samples. Required: `in_ready` drops to 0 after sample 16; pair 0 of frame 0 is held stable. Release `out_ready`: required `in_ready` returns to 1 the cycle after the 4th pair handshake.
- **Resync on `in_sof`:** send 5 samples, then `in_sof` with `16'h0182` followed by 7 more samples. Required: the first `out_a` is `16'h0182`; the 5 stale samples never appear.
- **Reset mid-frame:** assert `rst=0` mid-frame and mid-drain. Required: outputs go to their reset values immediately; the next full frame is emitted correctly.
- **Boundary values:** send samples `16'h7F80`, `16'h807F`, `16'hFFFF`, `16'h0000`. Required: they appear bit-exact at their bit-reversed positions.
